sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path delay-feedback (R2SDF) stage of the 64-point FFT.

---
 rtl/sdf_stage_ctrl.sv | 152 +++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// Control sequencer for one radix-2 single-path delay-feedback FFT stage:
// delay-FIFO enables, butterfly select, twiddle index and output framing.
module sdf_stage_ctrl #(
    parameter int INDEX = 5,
    parameter int DELAY = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    output logic             in_ready,
    output logic             fifo_w_en,
    output logic             fifo_r_en,
    output logic             bfly_sel,
    output logic [INDEX-1:0] twiddle_idx,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BFLY,
        PASS,
        DRAIN
    } state_t;

    localparam logic [INDEX-1:0] CNT_LAST = INDEX'(DELAY - 1);
    localparam logic [INDEX-1:0] CNT_ONE  = INDEX'(1);

    state_t           state, state_nxt;
    logic [INDEX-1:0] cnt, cnt_nxt, cnt_inc;
    logic             cnt_zero, cnt_last;
    logic             err_nxt;

    logic             ready_c, w_c, r_c, ov_c, bsel_c, sop_c, eop_c;
    logic [INDEX-1:0] tw_c;

    assign cnt_inc  = cnt + CNT_ONE;
    assign cnt_zero = (cnt == '0);
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        ready_c   = 1'b1;
        w_c       = 1'b0;
        r_c       = 1'b0;
        ov_c      = 1'b0;
        bsel_c    = 1'b0;
        tw_c      = '0;
        sop_c     = 1'b0;
        eop_c     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        w_c       = 1'b1;
                        cnt_nxt   = CNT_ONE;
                        state_nxt = FILL;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    w_c     = 1'b1;
                    err_nxt = in_sop;
                    cnt_nxt = cnt_inc;
                    if (cnt_last) state_nxt = BFLY;
                end
            end
            BFLY: begin
                bsel_c = 1'b1;
                tw_c   = cnt;
                if (in_valid) begin
                    w_c     = 1'b1;
                    r_c     = 1'b1;
                    ov_c    = 1'b1;
                    sop_c   = cnt_zero;
                    err_nxt = in_sop;
                    cnt_nxt = cnt_inc;
                    if (cnt_last) state_nxt = PASS;
                end
            end
            PASS: begin
                if (cnt_zero) begin
                    // The first difference leaves now either way: with a new frame
                    // start it is paired with the write, otherwise this cycle opens
                    // the drain so the last output lands D cycles later.
                    ready_c = in_valid;
                    r_c     = 1'b1;
                    ov_c    = 1'b1;
                    cnt_nxt = CNT_ONE;
                    if (in_valid && in_sop) begin
                        w_c = 1'b1;
                    end else begin
                        err_nxt   = in_valid;
                        state_nxt = DRAIN;
                    end
                end else if (in_valid) begin
                    w_c     = 1'b1;
                    r_c     = 1'b1;
                    ov_c    = 1'b1;
                    eop_c   = cnt_last;
                    err_nxt = in_sop;
                    cnt_nxt = cnt_inc;
                    if (cnt_last) state_nxt = BFLY;
                end
            end
            DRAIN: begin
                ready_c = 1'b0;
                r_c     = 1'b1;
                ov_c    = 1'b1;
                eop_c   = cnt_last;
                cnt_nxt = cnt_inc;
                if (cnt_last) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset also masks the IDLE decode so nothing fires while rst_n is held low.
    assign in_ready    = ready_c | ~rst_n;
    assign fifo_w_en   = w_c & rst_n;
    assign fifo_r_en   = r_c & rst_n;
    assign out_valid   = ov_c & rst_n;
    assign bfly_sel    = bsel_c & rst_n;
    assign twiddle_idx = rst_n ? tw_c : '0;
    assign out_sop     = sop_c & rst_n;
    assign out_eop     = eop_c & rst_n;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Scoreboard bench for sdf_stage_ctrl: expected output beats are queued with
// their cycle numbers when a scenario is set up and popped as out_valid appears.
module tb_sdf_stage_ctrl;

    localparam int INDEX = 5;
    localparam int DELAY = 32;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sop = 1'b0;
    logic             in_ready, fifo_w_en, fifo_r_en, bfly_sel;
    logic [INDEX-1:0] twiddle_idx;
    logic             out_valid, out_sop, out_eop, err;

    sdf_stage_ctrl #(.INDEX(INDEX), .DELAY(DELAY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(in_ready), .fifo_w_en(fifo_w_en), .fifo_r_en(fifo_r_en),
        .bfly_sel(bfly_sel), .twiddle_idx(twiddle_idx), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic sop;
        logic eop;
        logic bsel;
        logic wen;
        int   tw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   tid = 0;
    int   rst_at = -1;
    bit   v_pat[MAXC];
    bit   s_pat[MAXC];
    bit   e_pat[MAXC];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s test=%0d cyc=%0d got=%0d exp=%0d", tag, tid, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic sop, input logic eop,
                        input logic bsel, input logic wen, input int tw);
        exp_t e;
        e.cyc = c; e.sop = sop; e.eop = eop; e.bsel = bsel; e.wen = wen; e.tw = tw;
        sb.push_back(e);
    endtask

    task automatic push_bfly(input int first, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) push(first + k - k0, k == 0, 1'b0, 1'b1, 1'b1, k);
    endtask

    task automatic push_drain(input int first);
        for (int k = 0; k < DELAY; k++) push(first + k, 1'b0, k == DELAY - 1, 1'b0, 1'b0, 0);
    endtask

    task automatic monitor();
        exp_t e;
        check_eq("err", err, e_pat[cyc]);
        check_eq("wen_no_acc", fifo_w_en & ~(in_valid & in_ready), 0);
        check_eq("ren_vs_ov", fifo_r_en, out_valid);
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexp_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("out_cyc", cyc, e.cyc);
                check_eq("out_sop", out_sop, e.sop);
                check_eq("out_eop", out_eop, e.eop);
                check_eq("bfly_sel", bfly_sel, e.bsel);
                check_eq("w_en_out", fifo_w_en, e.wen);
                check_eq("twiddle", twiddle_idx, e.tw);
            end
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check_eq("miss_out", 0, 1);
            void'(sb.pop_front());
        end
        if (tid == 1) begin
            check_eq("t6_bsel", bfly_sel, (cyc >= 32 && cyc <= 63));
            check_eq("t6_tw", twiddle_idx, (cyc >= 32 && cyc <= 63) ? cyc - 32 : 0);
            if (cyc < 64) check_eq("fill_wen", fifo_w_en, 1);
            if (cyc >= 64 && cyc <= 95) check_eq("drain_rdy", in_ready, 0);
            if (cyc == 96) check_eq("idle_rdy", in_ready, 1);
        end
        if (tid == 3 && cyc >= 40 && cyc <= 42) check_eq("stall_wen", fifo_w_en, 0);
        if (tid == 4 && cyc == 0) check_eq("drop_wen", fifo_w_en, 0);
        if (tid == 4 && cyc == 3) check_eq("start_wen", fifo_w_en, 1);
        if (cyc == rst_at) begin
            check_eq("rst_rdy", in_ready, 1);
            check_eq("rst_wen", fifo_w_en, 0);
            check_eq("rst_ov", out_valid, 0);
            check_eq("rst_bsel", bfly_sel, 0);
            check_eq("rst_tw", twiddle_idx, 0);
        end
    endtask

    task automatic run_test(input int n);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check_eq("reset_rdy", in_ready, 1);
        check_eq("reset_ov", out_valid, 0);
        check_eq("reset_err", err, 0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 0; c < n; c++) begin
            in_valid = v_pat[c];
            in_sop   = s_pat[c];
            if (c == rst_at) rst_n = 1'b0;
            @(negedge clk);
            monitor();
            if (c == rst_at) begin
                in_valid = 1'b0;
                in_sop   = 1'b0;
                rst_n    = 1'b1;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("sb_empty", sb.size(), 0);
        sb.delete();
        rst_at = -1;
        for (int c = 0; c < MAXC; c++) begin
            v_pat[c] = 1'b0; s_pat[c] = 1'b0; e_pat[c] = 1'b0;
        end
    endtask

    initial begin
        // T1/T6: single frame
        tid = 1;
        for (int c = 0; c < 64; c++) v_pat[c] = 1'b1;
        s_pat[0] = 1'b1;
        push_bfly(32, 0, 32);
        push_drain(64);
        run_test(100);

        // T2: two frames back to back
        tid = 2;
        for (int c = 0; c < 128; c++) v_pat[c] = 1'b1;
        s_pat[0] = 1'b1;
        s_pat[64] = 1'b1;
        push_bfly(32, 0, 32);
        for (int k = 0; k < DELAY; k++) push(64 + k, 1'b0, k == DELAY - 1, 1'b0, 1'b1, 0);
        push_bfly(96, 0, 32);
        push_drain(128);
        run_test(165);

        // T3: stall in the butterfly half
        tid = 3;
        for (int c = 0; c < 67; c++) v_pat[c] = !(c >= 40 && c <= 42);
        s_pat[0] = 1'b1;
        push_bfly(32, 0, 8);
        push_bfly(43, 8, 24);
        push_drain(67);
        run_test(102);

        // T4: drop in IDLE, stray sop mid-frame
        tid = 4;
        v_pat[0] = 1'b1;
        e_pat[1] = 1'b1;
        for (int c = 3; c < 67; c++) v_pat[c] = 1'b1;
        s_pat[3] = 1'b1;
        s_pat[13] = 1'b1;
        e_pat[14] = 1'b1;
        push_bfly(35, 0, 32);
        push_drain(67);
        run_test(105);

        // T5: reset mid-butterfly, then a clean frame
        tid = 5;
        for (int c = 0; c < 46; c++) v_pat[c] = 1'b1;
        s_pat[0] = 1'b1;
        s_pat[45] = 1'b1;
        rst_at = 45;
        push_bfly(32, 0, 13);
        run_test(50);

        tid = 1;
        for (int c = 0; c < 64; c++) v_pat[c] = 1'b1;
        s_pat[0] = 1'b1;
        push_bfly(32, 0, 32);
        push_drain(64);
        run_test(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
